// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage register with optional 2-entry skid buffer,
// synchronous flush to bubble, and a saturating stall-cycle counter.
module pipe_stage_skid #(
  parameter int                 CTRL_W      = 16,
  parameter int                 DATA_W      = 160,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL = {CTRL_W{1'b0}},
  parameter bit                 SKID        = 1'b1,
  parameter int                 CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              FLUSH,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  // State encoding is {M_v, S_v}; 2'b01 is never reachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    FULL  = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_INC = 1;

  state_e            st_q, st_d;
  logic [CTRL_W-1:0] m_c_q, m_c_d;
  logic [DATA_W-1:0] m_d_q, m_d_d;
  logic [CTRL_W-1:0] s_c_q, s_c_d;
  logic [DATA_W-1:0] s_d_q, s_d_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              m_v, s_v;
  logic              accept, pop;

  assign m_v = st_q[1];
  assign s_v = st_q[0];

  assign in_ready = SKID ? ~s_v : (~m_v | out_ready);
  assign accept   = in_valid & in_ready;
  assign pop      = m_v & out_ready;

  assign out_valid = m_v;
  assign out_ctrl  = m_c_q;
  assign out_data  = m_d_q;
  assign stall_cnt = cnt_q;

  always_comb begin
    st_d  = st_q;
    m_c_d = m_c_q;
    m_d_d = m_d_q;
    s_c_d = s_c_q;
    s_d_d = s_d_q;
    if (FLUSH) begin
      st_d  = EMPTY;
      m_c_d = BUBBLE_CTRL;
      m_d_d = '0;
      s_c_d = BUBBLE_CTRL;
      s_d_d = '0;
    end else if (SKID) begin
      unique case (st_q)
        EMPTY: begin
          if (accept) begin
            st_d  = ONE;
            m_c_d = in_ctrl;
            m_d_d = in_data;
          end
        end
        ONE: begin
          unique case (1'b1)
            accept & pop: begin
              m_c_d = in_ctrl;
              m_d_d = in_data;
            end
            accept & ~pop: begin
              st_d  = FULL;
              s_c_d = in_ctrl;
              s_d_d = in_data;
            end
            ~accept & pop: begin
              st_d  = EMPTY;
              m_c_d = BUBBLE_CTRL;
              m_d_d = '0;
            end
            default: ;
          endcase
        end
        FULL: begin
          if (pop) begin
            st_d  = ONE;
            m_c_d = s_c_q;
            m_d_d = s_d_q;
            s_c_d = BUBBLE_CTRL;
            s_d_d = '0;
          end
        end
        default: begin
          st_d  = EMPTY;
          m_c_d = BUBBLE_CTRL;
          m_d_d = '0;
          s_c_d = BUBBLE_CTRL;
          s_d_d = '0;
        end
      endcase
    end else begin
      if (accept) begin
        st_d  = ONE;
        m_c_d = in_ctrl;
        m_d_d = in_data;
      end else if (pop) begin
        st_d  = EMPTY;
        m_c_d = BUBBLE_CTRL;
        m_d_d = '0;
      end
    end
  end

  // Flush does not touch the counter; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (m_v && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_INC;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q  <= EMPTY;
      m_c_q <= BUBBLE_CTRL;
      m_d_q <= '0;
      s_c_q <= BUBBLE_CTRL;
      s_d_q <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(s_v && !m_v));
      st_q  <= st_d;
      m_c_q <= m_c_d;
      m_d_q <= m_d_d;
      s_c_q <= s_c_d;
      s_d_q <= s_d_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed decode/execute stage register.
- Carries one pipeline stage's control bundle and data bundle between any two stages through a valid/ready handshake, with an optional 2-entry skid buffer so back-pressure is registered.
- Synchronous flush inserts bubbles, and the output control bundle is forced to a parameterised "inactive" pattern whenever the stage holds no valid entry.
- Includes a saturating stall-cycle counter for performance debug.

Parameters:
- CTRL_W, 16: width of control bundle (write-enable, ALU op, mux selects, ...).
- DATA_W, 160: width of data bundle (operands, PC+4, immediates, ...).
- BUBBLE_CTRL, {CTRL_W{1'b0}}: control pattern presented on bubbles/reset. Bits whose inactive level is 1, e.g. active-low WEN/DREQ, are set here.
- SKID, 1: 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16: stall counter width.

Ports:
- CLK, input, 1: clock; all state updates on rising edge.
- RST, input, 1: synchronous active-high reset.
- FLUSH, input, 1: synchronous flush; discard all held entries and any entry accepted in the same cycle.
- in_valid, input, 1: upstream entry valid.
- in_ready, output, 1: stage can accept an entry this cycle.
- in_ctrl, input, CTRL_W: upstream control bundle.
- in_data, input, DATA_W: upstream data bundle.
- out_valid, output, 1: head entry valid.
- out_ready, input, 1: downstream accepts head this cycle.
- out_ctrl, output, CTRL_W: head control; BUBBLE_CTRL when out_valid=0.
- out_data, output, DATA_W: head data; all zeros when out_valid=0.
- stall_cnt, output, CNT_W: count of cycles with out_valid=1 and out_ready=0; saturating.

Behaviour:
- Storage: main entry M (the head) and skid entry S. Each has a valid bit, ctrl and data. S exists only when SKID=1.
- Handshakes:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Order is strictly FIFO.
- SKID=1 states (M_v, S_v):
  - EMPTY (0,0):
    - accept -> ONE.
  - ONE (1,0):
    - accept & pop -> ONE; M loads the input.
    - accept & ~pop -> FULL; S loads the input.
    - ~accept & pop -> EMPTY.
    - ~accept & ~pop -> stay.
  - FULL (1,1): in_ready=0, so no accept.
    - pop -> ONE; S moves to M and S is cleared.
    - no pop -> stay; hold both entries.
  - (0,1) is unreachable; reaching it is an assertion error.
- SKID=1 in_ready = ~S_v. It is a register output with no combinational path from out_ready.
- SKID=0:
  - in_ready = ~M_v | out_ready (combinational).
  - M loads on accept; M_v clears on pop without accept.
- Outputs:
  - out_valid = M_v.
  - out_ctrl/out_data come from M when M_v=1; otherwise BUBBLE_CTRL and 0.
  - M and S payload registers are also written with BUBBLE_CTRL/0 when invalidated.
- FLUSH=1:
  - Next cycle M_v=S_v=0 and payloads hold the bubble values.
  - Any accept/pop in that cycle is ignored for state; upstream sees in_ready per the current state, but the accepted entry is dropped.
  - in_ready is 1 the cycle after a flush.
- RST=1: same effect as FLUSH, and stall_cnt <= 0. RST has priority over FLUSH.
- Reset values: out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, in_ready=1, stall_cnt=0.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & ~out_ready, saturating at 2^CNT_W-1.
  - Unaffected by FLUSH; cleared only by RST.
- Latency: an entry accepted at edge N is visible on out_* after edge N if the stage was empty. Throughput is 1 entry/cycle with out_ready held at 1.
- Payload is never modified in flight; the ctrl and data of a valid entry pass through bit-exact.

Test Plan:
- Reset then stream: RST 2 cycles, then in_valid=1 with ctrl=1..8 on consecutive cycles, out_ready=1 -> out_ctrl 1..8 on consecutive cycles, one cycle behind input; stall_cnt=0.
- Back-pressure: SKID=1, stream ctrl=0x11,0x22,0x33 with out_ready=0 -> in_ready drops to 0 after 2 accepts; 0x33 is held upstream. Raising out_ready gives 0x11,0x22,0x33 in order with none lost or duplicated; stall_cnt = number of stalled valid cycles.
- Flush while FULL: FULL with 0xAA,0xBB, FLUSH=1 with in_valid=1 ctrl=0xCC -> next cycle out_valid=0, out_ctrl=BUBBLE_CTRL (use 0x0401 to check non-zero bubble), in_ready=1; 0xCC never appears.
- Simultaneous accept and pop in ONE: hold out_ready=1 and in_valid=1 for 100 cycles -> state stays ONE, no bubbles, 100 entries out.
- Counter saturation: CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds; FLUSH leaves it at 15; RST -> 0.
- SKID=0 variant: out_ready=0 with M valid -> in_ready=0 in the same cycle; out_ready=1 -> in_ready=1 combinationally and the new entry replaces M at the edge.
